regfile_mp: RTL and testbench

Parametrised multi-port integer register file with a per-register busy scoreboard and a sequenced zero-initialisation after reset. It serves the ID stage (operand reads, destination issue) and the WB stage (result writes) of the pipeline. It generalises the single-write, two-read file to NRD read ports and NWR write ports, with optional same-cycle write-to-read forwarding.

---
 rtl/rf_pkg.sv | 14 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 40 ++++
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared defaults, FSM state type and zero constant for the multi-port register file.
package rf_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_e;

    localparam logic [XLEN_DEF-1:0] RF_ZERO = '0;

endpackage

// File: rtl/regfile_mp_if.sv
// Port bundle between the ID/WB stages (master) and the register file (slave).
interface regfile_mp_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
);
    localparam int unsigned AW = $clog2(NREGS);

    logic [NRD-1:0]            rd_en;
    logic [NRD-1:0][AW-1:0]    rd_addr;
    logic [NRD-1:0][XLEN-1:0]  rd_data;
    logic [NRD-1:0]            rd_busy;
    logic [NWR-1:0]            wr_en;
    logic [NWR-1:0][AW-1:0]    wr_addr;
    logic [NWR-1:0][XLEN-1:0]  wr_data;
    logic                      iss_en;
    logic [AW-1:0]             iss_addr;
    logic                      ready;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_busy, ready
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_busy, ready
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: issue sets, writes clear, issue beats a same-cycle clear, x0 never busy.
module regfile_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned NWR   = 2,
    localparam int unsigned AW   = $clog2(NREGS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_clr,
    input  logic [AW-1:0]           init_addr,
    input  logic                    run,
    input  logic                    iss_en,
    input  logic [AW-1:0]           iss_addr,
    input  logic [NWR-1:0]          clr_en,
    input  logic [NWR-1:0][AW-1:0]  clr_addr,
    output logic [NREGS-1:0]        busy
);

    logic [NREGS-1:0] busy_d;

    // Clears are applied before the issue so the issue wins on a shared address
    always_comb begin
        busy_d = busy;
        if (init_clr) begin
            busy_d[init_addr] = 1'b0;
        end else if (run) begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (clr_en[w]) busy_d[clr_addr[w]] = 1'b0;
            end
            if (iss_en) busy_d[iss_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_d;
    end

endmodule

// File: rtl/regfile_mp.sv
// NRD-read / NWR-write integer register file with busy scoreboard and sequenced zero-init.
// Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEF,
    parameter int unsigned NREGS = NREGS_DEF,
    parameter int unsigned NRD   = 2,
    parameter int unsigned NWR   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);

    localparam int unsigned AW = $clog2(NREGS);

    typedef logic [AW-1:0]   addr_t;
    typedef logic [XLEN-1:0] data_t;

    rf_state_e state_q, state_d;
    addr_t     cnt_q, cnt_d;
    logic      ready_q;
    logic      init_we;
    logic      run;

    data_t mem_q [NREGS];
    data_t mem_d [NREGS];

    logic [NREGS-1:0]          busy;
    logic [NRD-1:0][XLEN-1:0]  rd_data_c;
    logic [NRD-1:0]            rd_busy_c;

    assign run = (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == RUN);
        end
    end

    // INIT walks every entry once, then hands over to RUN
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_we = 1'b0;
        case (state_q)
            INIT: begin
                init_we = 1'b1;
                cnt_d   = cnt_q + AW'(1);
                if (cnt_q == AW'(NREGS - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Later ports overwrite earlier ones, giving the highest index priority
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) mem_d[r] = mem_q[r];
        if (init_we) begin
            mem_d[cnt_q] = XLEN'(RF_ZERO);
        end else if (run) begin
            for (int unsigned w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && (bus.wr_addr[w] != '0))
                    mem_d[bus.wr_addr[w]] = bus.wr_data[w];
            end
        end
        mem_d[0] = XLEN'(RF_ZERO);
    end

    always_ff @(posedge clk) begin
        for (int unsigned r = 0; r < NREGS; r++) mem_q[r] <= mem_d[r];
    end

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_clr  (init_we),
        .init_addr (cnt_q),
        .run       (run),
        .iss_en    (bus.iss_en),
        .iss_addr  (bus.iss_addr),
        .clr_en    (bus.wr_en),
        .clr_addr  (bus.wr_addr),
        .busy      (busy)
    );

    // Combinational read muxes; x0, disabled ports and INIT all read as zero
    always_comb begin
        for (int unsigned i = 0; i < NRD; i++) begin
            rd_data_c[i] = XLEN'(RF_ZERO);
            rd_busy_c[i] = 1'b0;
            if (run && bus.rd_en[i] && (bus.rd_addr[i] != '0)) begin
                rd_data_c[i] = mem_q[bus.rd_addr[i]];
                rd_busy_c[i] = busy[bus.rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
                for (int unsigned w = 0; w < NWR; w++) begin
                    if (bus.wr_en[w] && (bus.wr_addr[w] == bus.rd_addr[i])) begin
                        rd_data_c[i] = bus.wr_data[w];
                        rd_busy_c[i] = 1'b0;
                    end
                end
`endif
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;
    assign bus.ready   = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: init sequence, write priority, x0, scoreboard, forwarding, mid-run reset.
module tb_regfile_mp;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NRD   = 2;
    localparam int unsigned NWR   = 2;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    regfile_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.rd_en    = '0;
        bus.rd_addr  = '0;
        bus.wr_en    = '0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input int p, input int a);
        bus.rd_en[p]   = 1'b1;
        bus.rd_addr[p] = 5'(a);
    endtask

    task automatic wr(input int p, input int a, input logic [31:0] d);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = 5'(a);
        bus.wr_data[p] = d;
    endtask

    task automatic iss(input int a);
        bus.iss_en   = 1'b1;
        bus.iss_addr = 5'(a);
    endtask

    // Starts on the negedge where rst_n was just released; drives ignored traffic during INIT
    task automatic init_and_sweep(input string pfx);
        for (int k = 0; k < int'(NREGS); k++) begin
            idle();
            wr(0, (k + 31) % 32, 32'hBAD0_0000 | 32'(k));
            wr(1, (k + 1) % 32, 32'hBAD1_0000 | 32'(k));
            iss((k + 31) % 32);
            rd(0, k);
            #1;
            check($sformatf("%s_init_ready_c%0d", pfx, k), 32'(bus.ready), 32'd0);
            if (k % 8 == 0) begin
                check($sformatf("%s_init_rdata_c%0d", pfx, k), bus.rd_data[0], 32'd0);
                check($sformatf("%s_init_rbusy_c%0d", pfx, k), 32'(bus.rd_busy[0]), 32'd0);
            end
            step();
        end
        idle();
        #1;
        check($sformatf("%s_ready_up", pfx), 32'(bus.ready), 32'd1);
        for (int a = 0; a < int'(NREGS); a += 2) begin
            rd(0, a);
            rd(1, a + 1);
            #1;
            check($sformatf("%s_sweep_data_x%0d", pfx, a), bus.rd_data[0], 32'd0);
            check($sformatf("%s_sweep_data_x%0d", pfx, a + 1), bus.rd_data[1], 32'd0);
            check($sformatf("%s_sweep_busy_x%0d", pfx, a), 32'(bus.rd_busy[0]), 32'd0);
            check($sformatf("%s_sweep_busy_x%0d", pfx, a + 1), 32'(bus.rd_busy[1]), 32'd0);
        end
        step();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        step();
        rd(0, 5);
        #1;
        check("rst_ready", 32'(bus.ready), 32'd0);
        check("rst_rdata", bus.rd_data[0], 32'd0);
        check("rst_rbusy", 32'(bus.rd_busy[0]), 32'd0);
        step();
        rst_n = 1'b1;
        init_and_sweep("boot");

        // Basic write then read; same-cycle read shows old or forwarded data
        idle(); wr(0, 5, 32'hDEADBEEF); rd(1, 5); #1;
        check("x5_same_cycle", bus.rd_data[1], BYP ? 32'hDEADBEEF : 32'd0);
        step();
        idle(); rd(0, 5); #1;
        check("x5_read", bus.rd_data[0], 32'hDEADBEEF);
        step();

        // Write-port priority
        idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); step();
        idle(); rd(0, 7); rd(1, 7); #1;
        check("x7_prio_p0", bus.rd_data[0], 32'h22);
        check("x7_prio_p1", bus.rd_data[1], 32'h22);
        idle(); bus.rd_addr[0] = 5'd7; #1;
        check("x7_rd_en_off", bus.rd_data[0], 32'd0);
        step();

        // x0 is hardwired zero and never busy
        idle(); wr(0, 0, 32'hFFFFFFFF); wr(1, 0, 32'hFFFFFFFF); iss(0); step();
        idle(); rd(0, 0); #1;
        check("x0_data", bus.rd_data[0], 32'd0);
        check("x0_busy", 32'(bus.rd_busy[0]), 32'd0);
        step();

        // Scoreboard: issue, issue+write, write alone
        idle(); iss(9); step();
        idle(); rd(0, 9); rd(1, 9); #1;
        check("x9_busy_p0", 32'(bus.rd_busy[0]), 32'd1);
        check("x9_busy_p1", 32'(bus.rd_busy[1]), 32'd1);
        step();
        idle(); wr(0, 9, 32'h99); iss(9); step();
        idle(); rd(0, 9); #1;
        check("x9_iss_wins", 32'(bus.rd_busy[0]), 32'd1);
        check("x9_data_99", bus.rd_data[0], 32'h99);
        step();
        idle(); wr(1, 9, 32'h77); rd(0, 9); #1;
        check("x9_busy_fwd", 32'(bus.rd_busy[0]), BYP ? 32'd0 : 32'd1);
        step();
        idle(); rd(0, 9); #1;
        check("x9_cleared", 32'(bus.rd_busy[0]), 32'd0);
        check("x9_data_77", bus.rd_data[0], 32'h77);
        step();

        // Read-after-write on a busy register
        idle(); wr(0, 3, 32'h01); step();
        idle(); iss(3); step();
        idle(); wr(0, 3, 32'hA5); rd(0, 3); #1;
        check("x3_raw_data", bus.rd_data[0], BYP ? 32'hA5 : 32'h01);
        check("x3_raw_busy", 32'(bus.rd_busy[0]), BYP ? 32'd0 : 32'd1);
        step();
        idle(); rd(0, 3); #1;
        check("x3_after", bus.rd_data[0], 32'hA5);
        check("x3_after_busy", 32'(bus.rd_busy[0]), 32'd0);
        step();
        idle(); wr(0, 3, 32'hB0); wr(1, 3, 32'hB1); rd(1, 3); #1;
        check("x3_fwd_prio", bus.rd_data[1], BYP ? 32'hB1 : 32'hA5);
        step();
        idle(); rd(0, 3); #1;
        check("x3_prio_stored", bus.rd_data[0], 32'hB1);
        step();

        // Asynchronous reset mid-run
        idle(); rd(0, 7); rd(1, 3); #1;
        check("pre_rst_x7", bus.rd_data[0], 32'h22);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.ready), 32'd0);
        check("mid_rst_x7", bus.rd_data[0], 32'd0);
        check("mid_rst_x3", bus.rd_data[1], 32'd0);
        step();
        rst_n = 1'b1;
        init_and_sweep("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
